// File: rtl/uart_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_deframer : 16x-oversampled UART receive deframer             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_deframer #(
    parameter int OSR         = 16,
    parameter int MID         = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_out,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       busy
);

    localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [TW-1:0] C_TICK_MID = TW'(MID);
    localparam logic [TW-1:0] C_TICK_END = TW'(OSR - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_MARK = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_rxs;

    generate
        if (SYNC_STAGES > 1) begin : g_sync_multi
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '1;
                else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            end
        end else begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '1;
                else     sync_q <= rx;
            end
        end
    endgenerate

    assign w_rxs = sync_q[SYNC_STAGES-1];

    state_t          state_q,  state_d;
    logic [TW-1:0]   tick_q,   tick_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q,  shift_d;
    logic            parbit_q, parbit_d;
    logic [1:0]      wls_q,    wls_d;
    logic            pen_q,    pen_d;
    logic            eps_q,    eps_d;
    logic            sp_q,     sp_d;
    logic [7:0]      rx_out_q, rx_out_d;
    logic            pe_q,     pe_d;
    logic            fe_q,     fe_d;
    logic            bi_q,     bi_d;
    logic            push_q,   push_d;

    logic w_tick_end;
    logic w_tick_mid;
    logic w_last_bit;
    logic w_exp_par;
    logic w_pe;
    logic w_bi;

    assign w_tick_end = (tick_q == C_TICK_END);
    assign w_tick_mid = (tick_q == C_TICK_MID);
    assign w_last_bit = (bitcnt_q == (3'd4 + {1'b0, wls_q}));
    // Shift register is cleared at frame start, so unused upper bits add nothing to the XOR.
    assign w_exp_par  = sp_q ? ~eps_q : ((^shift_q) ^ ~eps_q);
    assign w_pe       = pen_q & (parbit_q != w_exp_par);
    assign w_bi       = (shift_q == 8'h00) & ~parbit_q & ~w_rxs;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        parbit_d = parbit_q;
        wls_d    = wls_q;
        pen_d    = pen_q;
        eps_d    = eps_q;
        sp_d     = sp_q;
        rx_out_d = rx_out_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;
        push_d   = 1'b0;

        if (baud_pulse) begin
            case (state_q)
                S_IDLE: begin
                    if (!w_rxs) begin
                        state_d  = S_START;
                        tick_d   = '0;
                        bitcnt_d = '0;
                        shift_d  = '0;
                        parbit_d = 1'b0;
                        wls_d    = wls;
                        pen_d    = pen;
                        eps_d    = eps;
                        sp_d     = sp;
                    end
                end
                S_START: begin
                    if (w_tick_mid) begin
                        tick_d   = '0;
                        bitcnt_d = '0;
                        state_d  = w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick_end) begin
                        shift_d[bitcnt_q] = w_rxs;
                        tick_d            = '0;
                        bitcnt_d          = bitcnt_q + 1'b1;
                        if (w_last_bit) begin
                            state_d = pen_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick_end) begin
                        parbit_d = w_rxs;
                        tick_d   = '0;
                        state_d  = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick_end) begin
                        tick_d   = '0;
                        rx_out_d = shift_q;
                        pe_d     = w_pe;
                        fe_d     = ~w_rxs;
                        bi_d     = w_bi;
                        push_d   = 1'b1;
                        // Returning to idle at mid-stop lets a following start bit be caught early.
                        state_d  = w_bi ? S_WAIT_MARK : S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_WAIT_MARK: begin
                    if (w_rxs) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            parbit_q <= 1'b0;
            wls_q    <= 2'b00;
            pen_q    <= 1'b0;
            eps_q    <= 1'b0;
            sp_q     <= 1'b0;
            rx_out_q <= 8'h00;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
            push_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            parbit_q <= parbit_d;
            wls_q    <= wls_d;
            pen_q    <= pen_d;
            eps_q    <= eps_d;
            sp_q     <= sp_d;
            rx_out_q <= rx_out_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
            push_q   <= push_d;
        end
    end

    assign rx_out = rx_out_q;
    assign push   = push_q;
    assign pe     = pe_q;
    assign fe     = fe_q;
    assign bi     = bi_q;
    assign busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_deframer : self-checking bench for uart_rx_deframer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx_deframer;

    localparam int OSR = 16;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx         = 1'b1;
    logic [1:0] wls        = 2'b11;
    logic       pen        = 1'b0;
    logic       eps        = 1'b0;
    logic       sp         = 1'b0;
    logic [7:0] rx_out;
    logic       push, pe, fe, bi, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int div      = 4;
    int bcnt     = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } obs_t;

    typedef struct {
        logic [1:0] wls;
        logic       pen, eps, sp;
        logic [7:0] data;
        logic       par, stop;
        logic [7:0] exp_rx;
        logic       exp_pe, exp_fe, exp_bi;
    } vec_t;

    obs_t obs_q[$];
    vec_t vecs[11];

    uart_rx_deframer #(.OSR(OSR), .MID(7), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .rx         (rx),
        .wls        (wls),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .rx_out     (rx_out),
        .push       (push),
        .pe         (pe),
        .fe         (fe),
        .bi         (bi),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            bcnt++;
            if (bcnt >= div) begin
                bcnt       = 0;
                baud_pulse = 1'b1;
            end else begin
                baud_pulse = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (push === 1'b1) obs_q.push_back({rx_out, pe, fe, bi});
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (baud_pulse !== 1'b1);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) wait_tick();
    endtask

    // A zero stop bit is held only 12 ticks so the receiver's restart attempt sees a false start.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic par, input logic stop,
                              input bit flip_wls, input int gap);
        wls = w; pen = p; eps = e; sp = s;
        send_bit(1'b0, OSR);
        if (flip_wls) wls = ~w;
        for (int i = 0; i < 5 + int'(w); i++) send_bit(data[i], OSR);
        if (p) send_bit(par, OSR);
        if (stop) send_bit(1'b1, OSR);
        else      send_bit(1'b0, 12);
        send_bit(1'b1, gap);
    endtask

    task automatic pop_obs(output obs_t o);
        o = 'x;
        if (obs_q.size() > 0) o = obs_q.pop_front();
    endtask

    task automatic expect_push(input string name, input logic [7:0] xd, input logic xpe,
                               input logic xfe, input logic xbi);
        obs_t o;
        chk({name, "_npush"}, obs_q.size(), 1);
        pop_obs(o);
        chk({name, "_rx_out"}, o.d, xd);
        chk({name, "_pe"}, o.pe, xpe);
        chk({name, "_fe"}, o.fe, xfe);
        chk({name, "_bi"}, o.bi, xbi);
        obs_q.delete();
    endtask

    function automatic vec_t mk(input logic [1:0] w, input logic p, input logic e, input logic s,
                                input logic [7:0] d, input logic par, input logic stop,
                                input logic [7:0] xr, input logic xpe, input logic xfe,
                                input logic xbi);
        vec_t v;
        v.wls = w; v.pen = p; v.eps = e; v.sp = s; v.data = d; v.par = par; v.stop = stop;
        v.exp_rx = xr; v.exp_pe = xpe; v.exp_fe = xfe; v.exp_bi = xbi;
        return v;
    endfunction

    // Reference: frame rules stated as arithmetic on the whole character.
    function automatic obs_t model(input logic [7:0] data, input logic [1:0] w, input logic p,
                                   input logic e, input logic s, input logic par,
                                   input logic stop);
        int         n    = 5 + int'(w);
        logic [7:0] d    = data & 8'((1 << n) - 1);
        int         ones = $countones(d);
        logic       ep;
        obs_t       r;
        if (s) ep = ~e;
        else   ep = e ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
        r.d  = d;
        r.pe = p && (par != ep);
        r.fe = ~stop;
        r.bi = (d == 8'h00) && (!p || !par) && !stop;
        return r;
    endfunction

    logic [7:0] r_data;
    logic [1:0] r_w;
    logic       r_p, r_e, r_s, r_par, r_stop;
    obs_t       exp_o, o0, o1;

    initial begin
        vecs[0]  = mk(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(2'b01, 1'b1, 1'b1, 1'b0, 8'h2B, 1'b0, 1'b1, 8'h2B, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(2'b11, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(2'b10, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_out", rx_out, 8'h00);
        chk("reset_push", push, 1'b0);
        chk("reset_flags", {pe, fe, bi}, 3'b000);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        send_bit(1'b1, 2 * OSR);

        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].data, vecs[i].wls, vecs[i].pen, vecs[i].eps, vecs[i].sp,
                       vecs[i].par, vecs[i].stop, 1'b0, vecs[i].stop ? OSR : 2 * OSR);
            expect_push($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_pe,
                        vecs[i].exp_fe, vecs[i].exp_bi);
            chk($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
        end

        // False start: low for 4 ticks only.
        wls = 2'b11; pen = 1'b0;
        send_bit(1'b0, 4);
        chk("fstart_busy_hi", busy, 1'b1);
        send_bit(1'b1, 11);
        chk("fstart_busy_lo", busy, 1'b0);
        chk("fstart_npush", obs_q.size(), 0);

        // Break: three 8N1 frame times of zeros, then mark.
        send_bit(1'b0, 3 * 10 * OSR);
        expect_push("break", 8'h00, 1'b0, 1'b1, 1'b1);
        chk("break_busy_held", busy, 1'b1);
        send_bit(1'b1, 2 * OSR);
        chk("break_busy_released", busy, 1'b0);
        chk("break_no_extra_push", obs_q.size(), 0);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OSR);
        expect_push("after_break", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Reset during the data bits of 0x3C.
        wls = 2'b11; pen = 1'b0;
        send_bit(1'b0, OSR);
        send_bit(1'b0, OSR);
        send_bit(1'b0, OSR);
        send_bit(1'b1, OSR);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rx_out", rx_out, 8'h00);
        chk("midrst_flags", {push, pe, fe, bi}, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        rx  = 1'b1;
        rst = 1'b0;
        send_bit(1'b1, 12 * OSR);
        chk("midrst_npush", obs_q.size(), 0);

        // LCR word length flipped to 5 bits right after the start bit.
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, OSR);
        expect_push("wls_change", 8'hC3, 1'b0, 1'b0, 1'b0);

        // Back-to-back 8N1 frames with no idle gap.
        send_frame(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OSR);
        chk("b2b_npush", obs_q.size(), 2);
        pop_obs(o0);
        pop_obs(o1);
        chk("b2b_first", {o0.d, o0.pe, o0.fe, o0.bi}, {8'h01, 3'b000});
        chk("b2b_second", {o1.d, o1.pe, o1.fe, o1.bi}, {8'hFF, 3'b000});
        obs_q.delete();

        for (int k = 0; k < 30; k++) begin
            div    = int'($urandom_range(1, 4));
            r_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) r_data = 8'h00;
            r_w    = 2'($urandom_range(0, 3));
            r_p    = 1'($urandom_range(0, 1));
            r_e    = 1'($urandom_range(0, 1));
            r_s    = 1'($urandom_range(0, 1));
            r_par  = 1'($urandom_range(0, 1));
            r_stop = ($urandom_range(0, 7) != 0);
            exp_o  = model(r_data, r_w, r_p, r_e, r_s, r_par, r_stop);
            send_frame(r_data, r_w, r_p, r_e, r_s, r_par, r_stop, 1'b0,
                       r_stop ? int'($urandom_range(0, OSR)) : 2 * OSR);
            expect_push($sformatf("rnd%0d", k), exp_o.d, exp_o.pe, exp_o.fe, exp_o.bi);
        end

        send_bit(1'b1, 2 * OSR);
        chk("final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side serial deframer for the UART; counterpart to the transmit stage.
- Consumes the asynchronous `rx` pin and the 16x `baud_pulse` from the shared baud generator, which the DLL/DLM divisor drives.
- Recovers each frame using the LCR word-length and parity fields.
- Pushes each character plus its error flags into the RX FIFO with a one-cycle `push` strobe.

Parameters:
- OSR, 16, baud_pulse ticks per bit period.
- MID, 7, tick index within a bit at which the line is sampled (centre of bit).
- SYNC_STAGES, 2, flip-flops in the `rx` metastability synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous active-high
- baud_pulse  in  1  one-clk-wide 16x oversample enable
- rx  in  1  serial input, idle high
- wls  in  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- pen  in  1  parity enable
- eps  in  1  even parity select (1=even, 0=odd)
- sp  in  1  stick parity
- rx_out  out  8  received character, LSB first, unused upper bits 0
- push  out  1  one-clk write strobe to RX FIFO
- pe  out  1  parity error for rx_out, valid with push
- fe  out  1  framing error (stop bit sampled 0), valid with push
- bi  out  1  break indication, valid with push
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `rst`.
- Reset:
  - state=IDLE, tick counter=0, bit counter=0.
  - rx_out=0x00, push=0, pe=fe=bi=0, busy=0.
  - Synchroniser flops preset to 1.
- Reset mid-frame: the partial character is discarded and no push is issued.
- Sampling rules:
  - All sampling uses the synchronised `rx` (rxs).
  - All state advances occur only on clk edges where baud_pulse=1; the counter holds otherwise.
- State IDLE: on baud_pulse with rxs=0, go to START with tick=0. Latch wls/pen/eps/sp into frame config; mid-frame LCR changes are ignored.
- State START: tick increments per baud_pulse. At tick==MID, sample rxs:
  - rxs=0: valid start; go to DATA with tick=0, bitcnt=0.
  - rxs=1: false start; return to IDLE, no push.
- State DATA:
  - At tick==OSR-1, sample rxs into shift position bitcnt (LSB first), then tick=0, bitcnt++.
  - After 5+wls bits: go to PARITY if pen=1, else STOP.
- State PARITY: at tick==OSR-1, sample the parity bit. Expected value:
  - sp=0: chosen so the count of data ones plus parity is even if eps=1, odd if eps=0.
  - sp=1: expected bit is ~eps (1 when eps=0, 0 when eps=1).
  - pe_int = (sampled != expected).
- State STOP: at tick==OSR-1, sample the first stop bit only; stb is not an input, and additional stop bits are not checked.
  - fe_int = ~rxs.
  - bi_int = 1 if the data bits, the parity bit (if enabled) and the stop bit were all 0.
- Output update, on the same edge as the stop sample:
  - rx_out <= zero-extended data; pe/fe/bi <= pe_int/fe_int/bi_int.
  - push=1 on the next clk only, one cycle. Flags hold until the next push.
- Next state after the stop sample:
  - If bi_int=1: go to WAIT_MARK. Stay there until baud_pulse with rxs=1, then go to IDLE. Exactly one push per break, regardless of its length.
  - Otherwise go to IDLE immediately, so a new start bit can be detected from the mid-stop point.
- Latency: push asserts 1 clk after the mid-stop-bit sample, i.e. about (1 + data + parity) * OSR + MID + 1 baud_pulse ticks after the start-bit falling edge, plus SYNC_STAGES clks.
- busy=1 in START, DATA, PARITY, STOP and WAIT_MARK.
- Back-to-back frames with no idle gap are received without loss.

Test Plan:
- 8N1 (wls=11, pen=0): send 0xA5 with baud_pulse every 4 clks -> single-cycle push, rx_out=0xA5, pe=fe=bi=0; busy returns to 0.
- 5-bit odd parity (wls=00, pen=1, eps=0, sp=0):
  - Send 0x10 with parity 0 -> rx_out=0x10, pe=0.
  - Resend with parity 1 -> rx_out=0x10, pe=1.
- Stick parity (pen=1, sp=1, eps=0), 7-bit 0x55 with parity bit 0 -> pe=1. With parity bit 1 -> pe=0.
- False start: rx low for 4 baud_pulse ticks then high -> no push, busy drops to 0 after tick MID.
- Break: rx held 0 for 3 frame times, then 1 -> exactly one push with rx_out=0x00, fe=1, bi=1. No further push until rx returns high and a new valid frame is sent.
- Corner cases:
  - Assert rst during DATA of 0x3C -> no push, all outputs 0.
  - Change wls mid-frame -> the frame still decodes using the latched config.
  - Two back-to-back 8N1 frames 0x01 then 0xFF with no gap -> two pushes, values correct.
